// File: rtl/color_stream_if.sv
// Handshake and output bundle of the color stream transmitter.
// The upstream producer drives in_valid and in_color. The transmitter drives
// everything else, including the registered color symbol and its status.
`timescale 1ns/1ps
interface color_stream_if;
  logic       in_valid;
  logic [1:0] in_color;
  logic       in_ready;
  logic       out_valid;
  logic [1:0] color;
  logic [7:0] fill_cnt;
  logic       err;

  // Upstream / observer side.
  modport master (
    output in_valid, in_color,
    input  in_ready, out_valid, color, fill_cnt, err
  );

  // Transmitter side.
  modport slave (
    input  in_valid, in_color,
    output in_ready, out_valid, color, fill_cnt, err
  );
endinterface

// File: rtl/color_stream_tx.sv
// Color stream transmitter.
// Requested colors are buffered in a small FIFO and emitted one per cycle on a
// registered output. No two consecutive emitted colors are equal: when the
// FIFO head matches the last emitted color, a filler color is sent first.
//
// Handshake: a push happens on a rising edge where in_valid && in_ready.
// in_ready depends only on registered occupancy, so it never depends on
// in_valid. A full FIFO refuses a push even if it pops on the same edge.
// Color 3 is consumed on handshake but never stored, and it sets err.
`timescale 1ns/1ps
module color_stream_tx #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  color_stream_if.slave bus
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // color_r also serves as "last": it always holds the most recently emitted
  // color, and it keeps that value across idle gaps.
  logic [1:0] color_r;
  logic       out_valid_r;
  logic       have_last;
  logic [7:0] fill_cnt_r;
  logic       err_r;

  logic       full;
  logic       empty;
  logic       push_hs;
  logic       push;
  logic [1:0] head;
  logic       emit_head;
  logic       emit_fill;
  logic [1:0] filler;

  // Derive the handshake, the emission decision and the filler choice.
  always_comb begin
    full      = (count == FULL_CNT);
    empty     = (count == '0);
    push_hs   = bus.in_valid && !full;
    push      = push_hs && (bus.in_color != 2'd3);
    head      = mem[rd_ptr];
    emit_head = !empty && (!have_last || (head != color_r));
    emit_fill = !empty && have_last && (head == color_r);
    // Smallest legal color different from the last one sent.
    filler    = (color_r == 2'd0) ? 2'd1 : 2'd0;
  end

  // FIFO storage. No reset: pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_color;
  end

  // Pointers, occupancy, output register and status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      color_r     <= 2'd0;
      out_valid_r <= 1'b0;
      have_last   <= 1'b0;
      fill_cnt_r  <= 8'd0;
      err_r       <= 1'b0;
    end else begin
      if (push)      wr_ptr <= wr_ptr + 1'b1;
      if (emit_head) rd_ptr <= rd_ptr + 1'b1;

      case ({push, emit_head})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (push_hs && (bus.in_color == 2'd3)) err_r <= 1'b1;

      if (emit_head) begin
        color_r     <= head;
        out_valid_r <= 1'b1;
        have_last   <= 1'b1;
      end else if (emit_fill) begin
        // Head stays put; it is guaranteed to differ from the filler next cycle.
        color_r     <= filler;
        out_valid_r <= 1'b1;
        if (fill_cnt_r != 8'hFF) fill_cnt_r <= fill_cnt_r + 8'd1;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = out_valid_r;
  assign bus.color     = color_r;
  assign bus.fill_cnt  = fill_cnt_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_color_stream_tx.sv
// Bench for color_stream_tx: directed steps, scoreboard of expected emitted
// colors built from the pushed requests, monitor comparing each output symbol.
`timescale 1ns/1ps
module tb_color_stream_tx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  color_stream_if bus();

  color_stream_tx #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int         compared   = 0;
  int         mismatched = 0;
  logic [1:0] exp_q[$];
  logic [1:0] last_m;
  logic       have_last_m;
  logic [7:0] fill_exp;
  logic       err_exp;
  int         accepted;
  logic       saw_full;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected emitted sequence for one accepted request.
  function automatic void model_push(input logic [1:0] c);
    logic [1:0] f;
    if (c == 2'd3) begin
      err_exp = 1'b1;
    end else begin
      if (have_last_m && (c == last_m)) begin
        f = (last_m == 2'd0) ? 2'd1 : 2'd0;
        exp_q.push_back(f);
        last_m = f;
        if (fill_exp != 8'hFF) fill_exp = fill_exp + 8'd1;
      end
      exp_q.push_back(c);
      last_m      = c;
      have_last_m = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    have_last_m = 1'b0;
    last_m      = 2'd0;
    fill_exp    = 8'd0;
    err_exp     = 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  // Offers c for one edge; returns right after that edge.
  task automatic push(input logic [1:0] c);
    logic acc;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_color = c;
    acc = bus.in_ready;
    if (!acc) saw_full = 1'b1;
    @(posedge clk);
    if (acc) begin
      accepted++;
      model_push(c);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1);
    idle(1);
    #1;
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_idle_valid"}, bus.out_valid, 1'b0);
    check({tag, "_fill_cnt"}, bus.fill_cnt, fill_exp);
    check({tag, "_err"}, bus.err, err_exp);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (!reset && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", bus.out_valid, 1'b0);
      end else begin
        check("color_seq", bus.color, exp_q.pop_front());
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_color = 2'd0;
    accepted     = 0;
    saw_full     = 1'b0;
    model_reset();

    #12;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_color", bus.color, 2'd0);
    check("rst_fill_cnt", bus.fill_cnt, 8'd0);
    check("rst_err", bus.err, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back 0,1,2 with one-edge latency.
    push(2'd0);
    push(2'd1);
    #1;
    check("t1_valid_e2", bus.out_valid, 1'b1);
    check("t1_color_e2", bus.color, 2'd0);
    push(2'd2);
    #1;
    check("t1_color_e3", bus.color, 2'd1);
    idle(1);
    #1;
    check("t1_valid_e4", bus.out_valid, 1'b1);
    check("t1_color_e4", bus.color, 2'd2);
    idle(1);
    #1;
    check("t1_valid_e5", bus.out_valid, 1'b0);
    check("t1_fill", bus.fill_cnt, 8'd0);
    drain("t1");

    // Repeated colors force fillers: 1,0,1 then 2,0,2.
    push(2'd1);
    push(2'd1);
    drain("t2a");
    check("t2a_fill_one", bus.fill_cnt, 8'd1);
    push(2'd2);
    push(2'd2);
    drain("t2b");
    check("t2b_fill_two", bus.fill_cnt, 8'd2);

    // Adjacency across an idle gap: 0, gap, then 0 -> 1,0.
    push(2'd0);
    drain("t3a");
    idle(3);
    push(2'd0);
    drain("t3b");
    check("t3_fill_three", bus.fill_cnt, 8'd3);

    // Illegal color while idle.
    push(2'd3);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      #1;
      check("t4_err", bus.err, 1'b1);
      check("t4_out_valid", bus.out_valid, 1'b0);
      check("t4_in_ready", bus.in_ready, 1'b1);
    end

    // Hold 2 for 12 cycles: alternating 2,0 output, FIFO fills.
    accepted = 0;
    saw_full = 1'b0;
    for (int i = 0; i < 12; i++) push(2'd2);
    check("t5_accepted", accepted, 9);
    check("t5_saw_full", saw_full, 1'b1);
    drain("t5");

    // Mid-stream asynchronous reset.
    push(2'd2);
    drain("t6a");
    push(2'd1);
    push(2'd0);
    #3;
    bus.in_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    check("t6_rst_out_valid", bus.out_valid, 1'b0);
    check("t6_rst_color", bus.color, 2'd0);
    check("t6_rst_fill", bus.fill_cnt, 8'd0);
    check("t6_rst_err", bus.err, 1'b0);
    check("t6_rst_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    push(2'd2);
    idle(1);
    #1;
    check("t6_post_valid", bus.out_valid, 1'b1);
    check("t6_post_color", bus.color, 2'd2);
    check("t6_post_fill", bus.fill_cnt, 8'd0);
    drain("t6b");

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/color_stream_tx.md
# color_stream_tx

Transmit-side driver for the 2-bit color stream that the coloring checker consumes. The block accepts requested colors from an upstream producer through a valid/ready port and buffers them in a small FIFO. It emits one color per cycle on a registered output. It guarantees that no two consecutive emitted colors are equal by inserting a filler color whenever the next requested color matches the last one sent. It sits directly in front of the coloring checker, which is wired to `color`, so in normal operation the checker never flags the stream.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream offers `in_color` this cycle.
- `in_color`  in  2  requested color; 0, 1 and 2 are legal, 3 is illegal.
- `in_ready`  out  1  FIFO not full; a push occurs on an edge where `in_valid && in_ready`.
- `out_valid`  out  1  `color` carries a new symbol this cycle (registered).
- `color`  out  2  emitted color (registered); connects to the checker's `color` input.
- `fill_cnt`  out  8  number of inserted fillers; saturates at 255.
- `err`  out  1  sticky; set when an illegal color is accepted.

## Operation
- Reset (async, immediate) clears the following:
  - FIFO is empty; `in_ready`=1.
  - `out_valid`=0, `color`=0, `fill_cnt`=0, `err`=0.
  - `have_last`=0, where `last` holds the most recently emitted color.
- Push handling:
  - A handshake carrying `in_color`∈{0,1,2} writes that color at the FIFO tail.
  - A handshake carrying `in_color`=3 is consumed (`in_ready` behaves as usual) but nothing is stored, and `err` is set to 1.
- Emission, evaluated each edge from the registered FIFO state. Let `h` be the FIFO head:
  - FIFO empty: `out_valid`←0; `color` and `last` hold.
  - Non-empty, and either `have_last`=0 or `h`≠`last`: `color`←`h`, `out_valid`←1, pop, `last`←`h`, `have_last`←1.
  - Non-empty and `h`==`last`: `color`←`f`, `out_valid`←1, no pop, `last`←`f`, `fill_cnt`←`fill_cnt`+1 (saturating).
    - `f` is the smallest value in {0,1,2} that differs from `last`: last=0→1, last=1→0, last=2→0.
    - On the next cycle `h`≠`last` is guaranteed, so `h` is emitted then.
- The adjacency rule spans idle gaps: `last` persists while `out_valid`=0.
- Full/empty handling:
  - `in_ready` is derived from registered occupancy only.
  - When the FIFO is full, a push is refused even if a pop occurs on the same edge.
  - A push into an empty FIFO is not bypassed to the output.
- Simultaneous push and pop when the FIFO is neither full nor empty: both happen and occupancy is unchanged.
- Pointers wrap modulo `DEPTH`. Occupancy needs log2(`DEPTH`)+1 bits so that full and empty are distinguishable.

## Timing
- Latency: a color pushed at edge k appears on `color` with `out_valid`=1 after edge k+1, provided the FIFO was empty and no filler is needed.
- Throughput: 1 symbol per cycle. Each filler costs one extra cycle, during which the FIFO does not drain.
- `err` and `fill_cnt` update on the same edge as the triggering event.
- A reset asserted mid-stream clears all state asynchronously. The first output after release behaves as if `have_last`=0.

## Test plan
- Push 0,1,2 on back-to-back cycles starting at edge 1 -> `color`=0,1,2 with `out_valid`=1 after edges 2,3,4; `fill_cnt`=0; then `out_valid`=0.
- Push 1,1 -> emitted sequence 1,0,1; `fill_cnt`=1. Push 2,2 -> emitted sequence 2,0,2.
- After emitting 0, idle for 3 cycles, then push 0 -> emitted sequence 1,0; the filler is inserted across the gap.
- Push 3 while idle -> `err`=1 and stays 1; `out_valid` stays 0; `in_ready` stays 1.
- Hold `in_valid`=1 with `in_color`=2 for 12 cycles -> output alternates 2,0,2,0,…; the FIFO fills to 4 and `in_ready` drops. Exactly `DEPTH`-limited pushes are accepted, with none lost or duplicated.
- Assert `reset` mid-stream between clock edges -> all outputs are 0 immediately and `in_ready`=1. After release, push 2 -> `color`=2 with no filler.
